// File: rtl/seg_scan_driver.sv
// seg_scan_driver: six-digit multiplexed 7-segment scanner with frame-aligned data latch.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_driver #(
  parameter int CLK_FREQ       = 50000000,
  parameter int SCAN_FREQ      = 1800,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit CS_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_50mhz,
  input  logic        rst_,
  input  logic [23:0] bcd_data,
  input  logic        data_load,
  input  logic [5:0]  dp_mask,
  output logic [7:0]  seg_data,
  output logic [5:0]  seg_cs,
  output logic        frame_done
);
  localparam int DIV_R = CLK_FREQ / SCAN_FREQ;
  localparam int DIV = DIV_R < 1 ? 1 : DIV_R;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [29:0]   pdat_q, pdat_d, shd_q, shd_d;
  logic [7:0]    seg_q, seg_d;
  logic [5:0]    cs_q, cs_d;
  logic          fd_q;
  logic          tick, wrap, blank;
  logic [3:0]    nib;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h3F; 4'h1: dec = 7'h06; 4'h2: dec = 7'h5B; 4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66; 4'h5: dec = 7'h6D; 4'h6: dec = 7'h7D; 4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F; 4'h9: dec = 7'h6F; 4'hA: dec = 7'h77; 4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39; 4'hD: dec = 7'h5E; 4'hE: dec = 7'h79; default: dec = 7'h71;
    endcase
  endfunction

  // Shadow ({dp, data}) moves only on the wrap edge; a load on that very edge bypasses pending.
  always_comb begin
    tick   = cnt_q == CNT_MAX;
    wrap   = tick && idx_q == 3'd5;
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = !tick ? idx_q : wrap ? 3'd0 : idx_q + 3'd1;
    pdat_d = data_load ? {dp_mask, bcd_data} : pdat_q;
    pend_d = wrap ? 1'b0 : pend_q | data_load;
    shd_d  = !wrap ? shd_q : data_load ? {dp_mask, bcd_data} : pend_q ? pdat_q : shd_q;
    nib    = shd_d[{idx_d, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
    blank  = idx_d != 3'd0 && (shd_d[23:0] >> {idx_d, 2'b00}) == 24'd0;
`else
    blank  = 1'b0;
`endif
    seg_d  = tick ? {shd_d[5'd24 + 5'(idx_d)], blank ? 7'h00 : dec(nib)} : seg_q;
    cs_d   = tick ? 6'b1 << idx_d : cs_q;
  end

  always_ff @(posedge clk_50mhz or negedge rst_) begin
    if (!rst_) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      pdat_q <= '0;
      shd_q  <= '0;
      seg_q  <= '0;
      cs_q   <= '0;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      pdat_q <= pdat_d;
      shd_q  <= shd_d;
      seg_q  <= seg_d;
      cs_q   <= cs_d;
      fd_q   <= wrap;
    end
  end

  assign seg_data   = seg_q ^ {8{SEG_ACTIVE_LOW}};
  assign seg_cs     = cs_q ^ {6{CS_ACTIVE_LOW}};
  assign frame_done = fd_q;
endmodule
